burst_reduce: RTL
=================

Name: burst_reduce

Overview:
- Parameterised word-stream reduction engine using the team's standard din/wen/rdy/dout/done block interface.
- Accepts a burst of N data words and reduces them with a selectable operator: unsigned sum, XOR, unsigned max or unsigned min.
- Reports the result with a one-cycle done pulse.
- Generalises the fixed 32-bit single-function block in data width, burst length and operating mode; sits between a producer FSM and a result register bank.

Parameters:
DATA_W, 32, data/result width in bits (>=2)
LEN_W, 8, burst-length field width; maximum burst is 2**LEN_W words

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
din  input  DATA_W  data word
wen  input  1  write enable; word accepted when wen && rdy
rdy  output  1  block can accept a word this cycle
mode  input  2  operator: 0 sum, 1 xor, 2 max, 3 min; sampled with first word only
len  input  LEN_W  burst length; sampled with first word only; 0 means 2**LEN_W
dout  output  DATA_W  reduction result, registered
done  output  1  one-cycle pulse, dout valid
ovf  output  1  sticky sum-overflow flag for the last burst; valid with done

Behaviour:
- Reset (async assert, sync deassert handled upstream) forces:
  - state IDLE; rdy=0 during reset, 1 from the first clock after deassert.
  - dout=0, done=0, ovf=0; internal acc, cnt, mode_q, len_q cleared.
- States: IDLE, ACCUM, DONE.
- IDLE: rdy=1.
  - On accept: acc<=din, cnt<=1, mode_q<=mode, len_q<=(len==0 ? 2**LEN_W : len), ovf_int<=0.
  - If effective len==1, go to DONE; else go to ACCUM.
- ACCUM: rdy=1. Each accept updates acc<=op(acc,din) and cnt<=cnt+1.
  - When the accepted word is word len_q (cnt==len_q-1 before increment), go to DONE.
  - wen=0 cycles hold everything; there is no timeout.
- Entering DONE: dout<=final acc value, including the word accepted in that same cycle.
- DONE (exactly 1 cycle): done=1, rdy=0, ovf reflects the burst; wen is ignored and no data is captured. Next state is IDLE.
- Latency: done asserts on the cycle after the last word is accepted. Best-case throughput is len+1 cycles per burst.
- dout and ovf hold their values until the next DONE; they are not cleared on IDLE entry.
- Operators (all unsigned, DATA_W wide):
  - sum: acc+din, see Optional Feature for overflow handling.
  - xor: acc^din.
  - max/min: unsigned compare; on a tie, acc is kept.
- ovf is always 0 for modes 1-3.
- mode and len changes mid-burst are ignored; only the values sampled on the first word are used.
- Counter cnt is LEN_W+1 bits so that a 2**LEN_W burst terminates correctly.
- Reset asserted mid-burst aborts the burst immediately: no done pulse, and dout returns to 0.

Optional Feature:
- Macro BURST_REDUCE_SAT_EN.
- Defined: sum mode saturates. If acc+din exceeds 2**DATA_W-1, acc becomes all ones and stays saturated for the rest of the burst; ovf is set sticky.
- Undefined: sum wraps modulo 2**DATA_W; ovf is still set sticky on any carry-out, so software can detect the wrap.
- Modes 1-3 are unaffected by the macro.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles, release -> dout=0, done=0, ovf=0, rdy=1 one clock after deassert.
- Sum, DATA_W=32, len=4, words 1,2,3,4 back-to-back, mode=0 -> done pulses 1 cycle after the 4th word; dout=10, ovf=0; rdy=0 during the done cycle.
- Sum overflow, len=2, words 0xFFFFFFF0 and 0x20 -> without macro: dout=0x00000010, ovf=1; with BURST_REDUCE_SAT_EN: dout=0xFFFFFFFF, ovf=1.
- Xor/max/min, len=3, words 0x0F,0xF0,0x33 with gaps (wen low 2 cycles between words) -> mode1 dout=0xCC, mode2 dout=0xF0, mode3 dout=0x0F; done only after the 3rd word.
- Boundary: LEN_W=2, len=0 -> burst of 4 words accepted; len=1 -> done the cycle after the single word; wen held high during the done cycle -> that word is ignored and the next burst starts at the following accept.
- Reset mid-burst: len=4, reset after 2 words -> no done pulse, dout=0; next full burst 5,5,5,5 sum -> dout=20.

Source files
------------

// File: rtl/burst_reduce_if.sv
// ---------------------------------------------------------------------------
// burst_reduce_if : din/wen/rdy/dout/done bundle for the burst reduction engine
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface burst_reduce_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic [DATA_W-1:0] din;
  logic              wen;
  logic              rdy;
  logic [1:0]        mode;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] dout;
  logic              done;
  logic              ovf;

  modport master (output din, wen, mode, len, input rdy, dout, done, ovf);
  modport slave  (input din, wen, mode, len, output rdy, dout, done, ovf);
endinterface

`default_nettype wire

// File: rtl/burst_reduce.sv
// ---------------------------------------------------------------------------
// burst_reduce : reduces a burst of N words with sum/xor/max/min, done pulse
// Optional macro BURST_REDUCE_SAT_EN makes sum mode saturate instead of wrap.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module burst_reduce #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  burst_reduce_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [LEN_W:0] C_ONE     = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] C_MAX_LEN = {1'b1, {LEN_W{1'b0}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_live;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] w_acc_nxt;
  logic [DATA_W:0]   w_sum;
  logic [LEN_W:0]    r_cnt;
  logic [LEN_W:0]    r_len;
  logic [LEN_W:0]    w_len_eff;
  logic [1:0]        r_mode;
  logic              r_ovf_acc;
  logic              r_ovf;
  logic              w_ovf_nxt;
  logic              w_rdy;
  logic              w_accept;
  logic              w_last;

  assign w_len_eff = (bus.len == '0) ? C_MAX_LEN : {1'b0, bus.len};
  assign w_sum     = {1'b0, r_acc} + {1'b0, bus.din};

  // Next accumulator value; the first word of a burst simply loads.
  always_comb begin
    w_acc_nxt = r_acc;
    w_ovf_nxt = r_ovf_acc;
    if (r_state == S_IDLE) begin
      w_acc_nxt = bus.din;
      w_ovf_nxt = 1'b0;
    end else begin
      case (r_mode)
        2'd0: begin
          w_ovf_nxt = r_ovf_acc | w_sum[DATA_W];
`ifdef BURST_REDUCE_SAT_EN
          w_acc_nxt = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`else
          w_acc_nxt = w_sum[DATA_W-1:0];
`endif
        end
        2'd1: w_acc_nxt = r_acc ^ bus.din;
        2'd2: if (bus.din > r_acc) w_acc_nxt = bus.din;
        default: if (bus.din < r_acc) w_acc_nxt = bus.din;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    w_last      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rdy    = r_live;
        w_accept = bus.wen & r_live;
        w_last   = (w_len_eff == C_ONE);
        if (w_accept) w_state_nxt = w_last ? S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        w_rdy    = 1'b1;
        w_accept = bus.wen;
        w_last   = (r_cnt == r_len - C_ONE);
        if (w_accept && w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // r_live keeps rdy low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live    <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_mode    <= 2'd0;
      r_ovf_acc <= 1'b0;
      r_dout    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_acc     <= w_acc_nxt;
        r_ovf_acc <= w_ovf_nxt;
        if (r_state == S_IDLE) begin
          r_cnt  <= C_ONE;
          r_mode <= bus.mode;
          r_len  <= w_len_eff;
        end else begin
          r_cnt <= r_cnt + C_ONE;
        end
        if (w_last) begin
          r_dout <= w_acc_nxt;
          r_ovf  <= w_ovf_nxt;
        end
      end
    end
  end

  assign bus.rdy  = w_rdy;
  assign bus.dout = r_dout;
  assign bus.done = (r_state == S_DONE);
  assign bus.ovf  = r_ovf;

endmodule

`default_nettype wire
